// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// No logic; pure declarations.
// Imported by the arbiter top and its round-robin picker.
package ram_arb_pkg;

  // Transaction sequencer states: wait for a request, model memory delay, return.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester identifiers: m0 = cache miss/writeback engine, m1 = TLB walker.
  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  // Width of the BUSY-cycle counter; covers LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin pick between m0 and m1.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  // A lone requester wins outright; on a tie the one not granted last time wins.
  always_comb begin
    grant_valid_o = |req_i;
    grant_id_o    = REQ_M0;
    if (req_i == 2'b11) begin
      grant_id_o = ~last_grant_i;
    end else if (req_i[1]) begin
      grant_id_o = REQ_M1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one write-port / async-read RAM between m0 (cache) and m1 (TLB walker).
// Latency: request seen in IDLE at cycle 0 -> ack at cycle LATENCY+1; one access per LATENCY+2.
// Backpressure: requesters hold req until their one-cycle ack; only one access in flight.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2   // legal range 1..15, bounded by CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_grant_q, last_grant_d;
  logic                    id_q, id_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    grant_valid;
  logic                    grant_id;
  logic                    win_we;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic                    last_busy;

  rr_arbiter2 u_rr (
    .req_i         ({m1_req, m0_req}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign win_we    = (grant_id == REQ_M1) ? m1_we    : m0_we;
  assign win_addr  = (grant_id == REQ_M1) ? m1_addr  : m0_addr;
  assign win_wdata = (grant_id == REQ_M1) ? m1_wdata : m0_wdata;

  // Final BUSY cycle: the write strobe fires and read data is captured here.
  // With LATENCY=1 the first BUSY cycle is also the last one.
  assign last_busy = (state_q == BUSY) && (cnt_q == CNT_LAST);

  // Sequencer next state: latch the winner in IDLE, count BUSY cycles, ack once.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = BUSY;
          cnt_d        = '0;
          id_d         = grant_id;
          last_grant_d = grant_id;
          we_d         = win_we;
          addr_d       = win_addr;
          wdata_d      = win_wdata;
        end
      end
      BUSY: begin
        if (last_busy) begin
          state_d = RESP;
          cnt_d   = '0;
          // Writes leave the shared read-data register untouched.
          if (!we_q) begin
            rdata_d = ram_dout;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= REQ_M1;  // so m0 wins the first tie
      id_q         <= REQ_M0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decode registered state only, so reset drops strobe and acks at once.
  assign ram_we    = last_busy && we_q;
  assign ram_waddr = addr_q;
  assign ram_raddr = addr_q;
  assign ram_din   = wdata_q;
  assign m0_ack    = (state_q == RESP) && (id_q == REQ_M0);
  assign m1_ack    = (state_q == RESP) && (id_q == REQ_M1);
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized two-requester traffic.
// A LATENCY=2 instance carries most tests; a LATENCY=1 instance covers the short build.
// Expected values come from arbitration/latency rules and a transaction-level memory model.
module tb_ram_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack, ram_we;
  logic [AW-1:0] m0_addr, m1_addr, ram_waddr, ram_raddr;
  logic [DW-1:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata, ram_din, ram_dout;

  logic          b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack, b_ram_we;
  logic [AW-1:0] b_m0_addr, b_m1_addr, b_ram_waddr, b_ram_raddr;
  logic [DW-1:0] b_m0_wdata, b_m0_rdata, b_m1_wdata, b_m1_rdata, b_ram_din, b_ram_dout;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .ram_we(b_ram_we), .ram_waddr(b_ram_waddr), .ram_din(b_ram_din),
    .ram_raddr(b_ram_raddr), .ram_dout(b_ram_dout)
  );

  // Backing RAMs: synchronous write, combinational read.
  logic [DW-1:0] mem_a [0:4095];
  logic [DW-1:0] mem_b [0:4095];
  always @(posedge clk) if (ram_we) mem_a[ram_waddr] <= ram_din;
  always @(posedge clk) if (b_ram_we) mem_b[b_ram_waddr] <= b_ram_din;
  assign ram_dout   = mem_a[ram_raddr];
  assign b_ram_dout = mem_b[b_ram_raddr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log for the LATENCY=2 instance, sampled mid-cycle.
  typedef struct { int cyc; int id; logic [DW-1:0] rd; } ack_t;
  ack_t acks[$];
  int   wes[$];
  always @(negedge clk) begin
    if (m0_ack) acks.push_back('{cyc, 0, m0_rdata});
    if (m1_ack) acks.push_back('{cyc, 1, m1_rdata});
    if (ram_we) wes.push_back(cyc);
  end

  // Transaction-level memory model for the random traffic.
  logic [DW-1:0] model [logic [AW-1:0]];
  logic [DW-1:0] shared_rd;
  bit            shared_ok;
  int            n_ack [2];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Drives one transaction from an idle bus and waits (bounded) for its ack.
  task automatic issue(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int c0, output int lat, output logic [DW-1:0] rd, output bit got);
    got = 1'b0; lat = -1; rd = '0;
    acks.delete(); wes.delete();
    step();
    c0 = cyc;
    set_m(m, 1'b1, we, a, d);
    for (int k = 1; k <= 40 && !got; k++) begin
      step();
      if ((m == 0) ? m0_ack : m1_ack) begin
        got = 1'b1; lat = cyc - c0; rd = (m == 0) ? m0_rdata : m1_rdata;
      end
    end
    set_m(m, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if ({m0_ack, m1_ack, ram_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {m0_ack, m1_ack, ram_we}); end
    checks++; if (ram_waddr !== '0 || ram_raddr !== '0) begin errors++; $display("FAIL reset_addr got %h/%h want 0", ram_waddr, ram_raddr); end
    checks++; if (ram_din !== '0) begin errors++; $display("FAIL reset_din got %h want 0", ram_din); end
    checks++; if (m0_rdata !== '0 || m1_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0", m0_rdata, m1_rdata); end
    checks++; if ({b_m0_ack, b_m1_ack, b_ram_we} !== 3'b000) begin errors++; $display("FAIL reset_l1_strobes got %b want 000", {b_m0_ack, b_m1_ack, b_ram_we}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int c0, lat; logic [DW-1:0] rd; bit got;
    issue(0, 1'b1, 12'h010, 32'hDEADBEEF, c0, lat, rd, got);
    checks++; if (!got || lat !== LAT + 1) begin errors++; $display("FAIL wr_ack_lat got %0d want %0d", lat, LAT + 1); end
    checks++; if (wes.size() !== 1) begin errors++; $display("FAIL wr_we_pulses got %0d want 1", wes.size()); end
    if (wes.size() > 0) begin
      checks++; if (wes[0] - c0 !== LAT) begin errors++; $display("FAIL wr_we_cycle got %0d want %0d", wes[0] - c0, LAT); end
    end
    repeat (3) step();
    checks++; if (acks.size() !== 1) begin errors++; $display("FAIL wr_ack_count got %0d want 1", acks.size()); end
    if (acks.size() > 0) begin
      checks++; if (acks[0].id !== 0) begin errors++; $display("FAIL wr_ack_id got %0d want 0", acks[0].id); end
    end
    issue(1, 1'b0, 12'h010, '0, c0, lat, rd, got);
    checks++; if (!got || lat !== LAT + 1) begin errors++; $display("FAIL rd_ack_lat got %0d want %0d", lat, LAT + 1); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd); end
    checks++; if (wes.size() !== 0) begin errors++; $display("FAIL rd_no_we got %0d want 0", wes.size()); end
  endtask

  task automatic test_round_robin();
    int c0, n0;
    int exp_id [3] = '{0, 1, 0};
    int exp_c  [3] = '{LAT + 1, 2 * LAT + 3, 3 * LAT + 5};
    int exp2_id [2] = '{1, 0};
    logic [DW-1:0] exp2_rd [2] = '{32'h31, 32'h30};
    do_reset();
    acks.delete();
    step(); c0 = cyc; n0 = 0;
    set_m(0, 1'b1, 1'b1, 12'h030, 32'h30);
    set_m(1, 1'b1, 1'b1, 12'h031, 32'h31);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (m0_ack) begin
        n0++;
        if (n0 == 1) set_m(0, 1'b1, 1'b1, 12'h032, 32'h32);
        else         set_m(0, 1'b0, 1'b0, '0, '0);
      end
      if (m1_ack) set_m(1, 1'b0, 1'b0, '0, '0);
    end
    checks++; if (acks.size() !== 3) begin errors++; $display("FAIL rr_count got %0d want 3", acks.size()); end
    for (int i = 0; i < acks.size() && i < 3; i++) begin
      checks++; if (acks[i].id !== exp_id[i] || acks[i].cyc - c0 !== exp_c[i])
        begin errors++; $display("FAIL rr_order[%0d] got m%0d@%0d want m%0d@%0d", i, acks[i].id, acks[i].cyc - c0, exp_id[i], exp_c[i]); end
    end
    acks.delete();
    step(); c0 = cyc;
    set_m(0, 1'b1, 1'b0, 12'h030, '0);
    set_m(1, 1'b1, 1'b0, 12'h031, '0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (m0_ack) set_m(0, 1'b0, 1'b0, '0, '0);
      if (m1_ack) set_m(1, 1'b0, 1'b0, '0, '0);
    end
    checks++; if (acks.size() !== 2) begin errors++; $display("FAIL rr2_count got %0d want 2", acks.size()); end
    for (int i = 0; i < acks.size() && i < 2; i++) begin
      checks++; if (acks[i].id !== exp2_id[i] || acks[i].rd !== exp2_rd[i])
        begin errors++; $display("FAIL rr2_order[%0d] got m%0d/%h want m%0d/%h", i, acks[i].id, acks[i].rd, exp2_id[i], exp2_rd[i]); end
    end
  endtask

  task automatic test_starvation();
    int c0, lat; logic [DW-1:0] rd; bit got;
    int exp_id [4] = '{0, 1, 0, 0};
    int exp_c  [4] = '{3, 7, 11, 15};
    logic [DW-1:0] exp_rd [4] = '{32'hA5A50001, 32'hDEADBEEF, 32'hA5A50001, 32'hA5A50001};
    issue(0, 1'b1, 12'h001, 32'hA5A50001, c0, lat, rd, got);
    acks.delete();
    step(); c0 = cyc;
    set_m(0, 1'b1, 1'b0, 12'h001, '0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) set_m(1, 1'b1, 1'b0, 12'h010, '0);
      if (m1_ack) set_m(1, 1'b0, 1'b0, '0, '0);
      if (k == 16) set_m(0, 1'b0, 1'b0, '0, '0);
    end
    repeat (4) step();
    checks++; if (acks.size() !== 4) begin errors++; $display("FAIL starve_count got %0d want 4", acks.size()); end
    for (int i = 0; i < acks.size() && i < 4; i++) begin
      checks++; if (acks[i].id !== exp_id[i] || acks[i].cyc - c0 !== exp_c[i] || acks[i].rd !== exp_rd[i])
        begin errors++; $display("FAIL starve[%0d] got m%0d@%0d=%h want m%0d@%0d=%h", i, acks[i].id, acks[i].cyc - c0, acks[i].rd, exp_id[i], exp_c[i], exp_rd[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int c0, lat; logic [DW-1:0] rd; bit got;
    issue(0, 1'b1, 12'h020, 32'h11112222, c0, lat, rd, got);
    // Abort a write in its first BUSY cycle.
    acks.delete(); wes.delete();
    step(); set_m(0, 1'b1, 1'b1, 12'h020, 32'h99999999);
    step();
    rst = 1'b1; #1;
    checks++; if (ram_we !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL rstA_strobes got we=%b ack=%b want 0/0", ram_we, m0_ack); end
    step(); step();
    set_m(0, 1'b0, 1'b0, '0, '0);
    step(); rst = 1'b0;
    checks++; if (wes.size() !== 0 || acks.size() !== 0) begin errors++; $display("FAIL rstA_no_event got we=%0d ack=%0d want 0/0", wes.size(), acks.size()); end
    issue(1, 1'b0, 12'h020, '0, c0, lat, rd, got);
    checks++; if (!got || lat !== LAT + 1) begin errors++; $display("FAIL rstA_idle_lat got %0d want %0d", lat, LAT + 1); end
    checks++; if (rd !== 32'h11112222) begin errors++; $display("FAIL rstA_mem got %h want 11112222", rd); end
    // Abort a write while its strobe is high: strobe drops before the edge.
    step(); set_m(0, 1'b1, 1'b1, 12'h020, 32'h77777777);
    step(); step();
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rstB_we_before got %b want 1", ram_we); end
    rst = 1'b1; #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rstB_we_async got %b want 0", ram_we); end
    step(); set_m(0, 1'b0, 1'b0, '0, '0);
    step(); rst = 1'b0;
    issue(1, 1'b0, 12'h020, '0, c0, lat, rd, got);
    checks++; if (rd !== 32'h11112222) begin errors++; $display("FAIL rstB_mem got %h want 11112222", rd); end
    // Abort during the ack cycle: ack drops before the edge.
    step(); set_m(1, 1'b1, 1'b0, 12'h020, '0);
    repeat (LAT + 1) step();
    checks++; if (m1_ack !== 1'b1) begin errors++; $display("FAIL rstC_ack_before got %b want 1", m1_ack); end
    rst = 1'b1; #1;
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL rstC_ack_async got %b want 0", m1_ack); end
    set_m(1, 1'b0, 1'b0, '0, '0);
    step(); step(); rst = 1'b0;
  endtask

  task automatic test_latency1();
    int we_at, ack_at; logic [DW-1:0] rd;
    step();
    b_m1_req = 1'b1; b_m1_we = 1'b1; b_m1_addr = 12'h0FF; b_m1_wdata = 32'h12345678;
    we_at = -1; ack_at = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (b_ram_we && we_at < 0) we_at = k;
      if (b_m1_ack && ack_at < 0) begin ack_at = k; b_m1_req = 1'b0; end
    end
    checks++; if (ack_at !== 2) begin errors++; $display("FAIL l1_wr_ack got %0d want 2", ack_at); end
    checks++; if (we_at !== 1) begin errors++; $display("FAIL l1_we_cycle got %0d want 1", we_at); end
    step();
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 12'h0FF;
    ack_at = -1; rd = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (b_m0_ack && ack_at < 0) begin ack_at = k; rd = b_m0_rdata; b_m0_req = 1'b0; end
    end
    checks++; if (ack_at !== 2) begin errors++; $display("FAIL l1_rd_ack got %0d want 2", ack_at); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL l1_rd_data got %h want 12345678", rd); end
  endtask

  task automatic rand_master(input int m);
    logic we; logic [AW-1:0] a; logic [DW-1:0] d, rd; int start, lat; bit got;
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(1, 3)) step();
      we = 1'($urandom_range(0, 1));
      a  = 12'h100 + 12'($urandom_range(0, 7));
      d  = $urandom;
      set_m(m, 1'b1, we, a, d);
      start = cyc; got = 1'b0; lat = -1; rd = '0;
      for (int k = 1; k <= 20 && !got; k++) begin
        step();
        if ((m == 0) ? m0_ack : m1_ack) begin
          got = 1'b1; lat = cyc - start; rd = (m == 0) ? m0_rdata : m1_rdata;
        end
      end
      set_m(m, 1'b0, 1'b0, '0, '0);
      checks++; if (!got || lat > 2 * LAT + 3) begin errors++; $display("FAIL rand_wait m%0d got=%0b lat=%0d max=%0d", m, got, lat, 2 * LAT + 3); end
      if (got) begin
        n_ack[m]++;
        if (!we) begin
          if (model.exists(a)) begin
            checks++; if (rd !== model[a]) begin errors++; $display("FAIL rand_rd m%0d addr %h got %h want %h", m, a, rd, model[a]); end
          end
          shared_ok = model.exists(a);
          shared_rd = rd;
        end else begin
          if (shared_ok) begin
            checks++; if (rd !== shared_rd) begin errors++; $display("FAIL rand_wr_rdata m%0d got %h want %h", m, rd, shared_rd); end
          end
          model[a] = d;
        end
      end
    end
  endtask

  task automatic test_random();
    model.delete(); shared_ok = 1'b0; n_ack[0] = 0; n_ack[1] = 0;
    fork
      rand_master(0);
      rand_master(1);
    join
    checks++; if (n_ack[0] !== 20 || n_ack[1] !== 20) begin errors++; $display("FAIL rand_ack_count got %0d/%0d want 20/20", n_ack[0], n_ack[1]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_starvation();
    test_reset_mid();
    test_latency1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
